// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter for the single-port data RAM (CPU MEM stage vs UART loader)
module dmem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              boot_lock,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_LIMIT);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              owner_ldr;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [WC_W-1:0]   wait_cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic [SC_W-1:0]   starve_nxt;

    logic in_issue;
    logic decide;
    logic capture;
    logic cpu_elig;
    logic ldr_elig;
    logic win_cpu;
    logic win_ldr;

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cpu_gnt    = 1'b0;
        ldr_gnt    = 1'b0;
        cpu_rvalid = 1'b0;
        ldr_rvalid = 1'b0;
        mem_we     = 1'b0;
        decide     = 1'b0;
        capture    = 1'b0;
        starve_nxt = starve_cnt;

        // A requester whose command is on the bus this cycle is still holding
        // req; excluding it here prevents the same command issuing twice.
        in_issue = (state == ISSUE);
        cpu_elig = cpu_req && !boot_lock && !(in_issue && !owner_ldr);
        ldr_elig = ldr_req && !(in_issue && owner_ldr);
        win_cpu  = cpu_elig && (!ldr_elig || (starve_cnt != SC_MAX));
        win_ldr  = ldr_elig && !win_cpu;

        case (state)
            IDLE: begin
                decide = 1'b1;
            end
            ISSUE: begin
                cpu_gnt = !owner_ldr;
                ldr_gnt = owner_ldr;
                mem_we  = cmd_we;
                decide  = cmd_we;
                if (!cmd_we) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (wait_cnt == WC_LAST) begin
                    capture   = 1'b1;
                    state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                cpu_rvalid = !owner_ldr;
                ldr_rvalid = owner_ldr;
                decide     = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (decide) begin
            state_nxt = (win_cpu || win_ldr) ? ISSUE : IDLE;
            if (!ldr_req || win_ldr) begin
                starve_nxt = '0;
            end else if (win_cpu && (starve_cnt != SC_MAX)) begin
                starve_nxt = starve_cnt + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            owner_ldr  <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            starve_cnt <= starve_nxt;

            // Owner is latched with the command so later req/boot_lock changes
            // cannot redirect a read already on its way back.
            if (decide && (win_cpu || win_ldr)) begin
                owner_ldr <= win_ldr;
                cmd_we    <= win_ldr ? ldr_we    : cpu_we;
                cmd_addr  <= win_ldr ? ldr_addr  : cpu_addr;
                cmd_wdata <= win_ldr ? ldr_wdata : cpu_wdata;
            end

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == RD_WAIT) begin
                wait_cnt <= wait_cnt + WC_W'(1);
            end

            if (capture) begin
                if (owner_ldr) begin
                    ldr_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter (RD_LAT=1 main instance, RD_LAT=3 timing instance)
module tb_dmem_arbiter;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic        boot_lock;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_gnt, ldr_rvalid;
    logic [15:0] ldr_addr;
    logic [31:0] ldr_wdata, ldr_rdata;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        b_boot_lock;
    logic        b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_rvalid;
    logic [15:0] b_cpu_addr;
    logic [31:0] b_cpu_wdata, b_cpu_rdata;
    logic        b_ldr_req, b_ldr_we, b_ldr_gnt, b_ldr_rvalid;
    logic [15:0] b_ldr_addr;
    logic [31:0] b_ldr_wdata, b_ldr_rdata;
    logic        b_mem_we;
    logic [15:0] b_mem_addr;
    logic [31:0] b_mem_wdata, b_mem_rdata;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .STARVE_LIMIT(8)) u_a (
        .clock(clock), .rst_n(rst_n), .boot_lock(boot_lock),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3), .STARVE_LIMIT(8)) u_b (
        .clock(clock), .rst_n(rst_n), .boot_lock(b_boot_lock),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .ldr_req(b_ldr_req), .ldr_we(b_ldr_we), .ldr_addr(b_ldr_addr), .ldr_wdata(b_ldr_wdata),
        .ldr_gnt(b_ldr_gnt), .ldr_rvalid(b_ldr_rvalid), .ldr_rdata(b_ldr_rdata),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Background RAM contents for never-written words.
    function automatic logic [31:0] pat(input logic [7:0] idx);
        return (idx == 8'd4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {24'h0, idx});
    endfunction

    bit [31:0] ram    [256];
    bit        ram_wr [256];
    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr[9:2]]    <= mem_wdata;
            ram_wr[mem_addr[9:2]] <= 1'b1;
        end
        mem_rdata <= ram_wr[mem_addr[9:2]] ? ram[mem_addr[9:2]] : pat(mem_addr[9:2]);
    end

    logic [31:0] b_p0, b_p1;
    always @(posedge clock) begin
        b_p0        <= pat(b_mem_addr[9:2]);
        b_p1        <= b_p0;
        b_mem_rdata <= b_p1;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] cpu_q [$];
    logic [31:0] ldr_q [$];
    bit   [31:0] exp_mem [256];
    bit          exp_wr  [256];

    function automatic logic [31:0] exp_word(input logic [15:0] addr);
        return exp_wr[addr[9:2]] ? exp_mem[addr[9:2]] : pat(addr[9:2]);
    endfunction

    logic [31:0] cpu_rd_exp = '0;
    logic [31:0] ldr_rd_exp = '0;
    int cpu_rv_cyc   = -1;
    int ldr_rv_cyc   = -1;
    int cpu_gnt_seen = 0;

    always @(posedge clock) begin
        #1;
        if (!rst_n) begin
            cpu_q.delete();
            ldr_q.delete();
            cpu_rd_exp = '0;
            ldr_rd_exp = '0;
        end else begin
            if (cpu_gnt) cpu_gnt_seen++;
            if (cpu_rvalid) begin
                cpu_rv_cyc = cyc;
                if (cpu_q.size() == 0) chk("cpu_rvalid_spurious", 64'(cpu_rvalid), 64'd0);
                else cpu_rd_exp = cpu_q.pop_front();
            end
            if (ldr_rvalid) begin
                ldr_rv_cyc = cyc;
                if (ldr_q.size() == 0) chk("ldr_rvalid_spurious", 64'(ldr_rvalid), 64'd0);
                else ldr_rd_exp = ldr_q.pop_front();
            end
        end
        chk("cpu_rdata", 64'(cpu_rdata), 64'(cpu_rd_exp));
        chk("ldr_rdata", 64'(ldr_rdata), 64'(ldr_rd_exp));
    end

    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [31:0] wd, output int gc);
        int n;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        if (!we) cpu_q.push_back(exp_word(addr));
        n = 0;
        tick();
        while (!cpu_gnt && n < 200) begin
            tick();
            n++;
        end
        gc = cyc;
        chk("cpu_gnt", 64'(cpu_gnt), 64'd1);
        chk("cpu_mem_addr", 64'(mem_addr), 64'(addr));
        chk("cpu_mem_we", 64'(mem_we), 64'(we));
        if (we) begin
            chk("cpu_mem_wdata", 64'(mem_wdata), 64'(wd));
            exp_mem[addr[9:2]] = wd;
            exp_wr[addr[9:2]]  = 1'b1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic ldr_op(input logic we, input logic [15:0] addr, input logic [31:0] wd, output int gl);
        int n;
        ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wd;
        if (!we) ldr_q.push_back(exp_word(addr));
        n = 0;
        tick();
        while (!ldr_gnt && n < 200) begin
            tick();
            n++;
        end
        gl = cyc;
        chk("ldr_gnt", 64'(ldr_gnt), 64'd1);
        chk("ldr_mem_addr", 64'(mem_addr), 64'(addr));
        chk("ldr_mem_we", 64'(mem_we), 64'(we));
        if (we) begin
            chk("ldr_mem_wdata", 64'(mem_wdata), 64'(wd));
            exp_mem[addr[9:2]] = wd;
            exp_wr[addr[9:2]]  = 1'b1;
        end
        ldr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int gc, gc2, gl, g, t0, base, prev;
        boot_lock = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        b_boot_lock = 1'b0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = '0; b_ldr_wdata = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_cpu_gnt", 64'(cpu_gnt), 64'd0);
        chk("rst_ldr_gnt", 64'(ldr_gnt), 64'd0);
        chk("rst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("rst_ldr_rvalid", 64'(ldr_rvalid), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_starve_cnt", 64'(u_a.starve_cnt), 64'd0);
        chk("rst_b_mem_addr", 64'(b_mem_addr), 64'd0);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_mem_we", 64'(mem_we), 64'd0);

        // single CPU read
        t0 = cyc;
        cpu_op(1'b0, 16'h0010, 32'h0, gc);
        chk("tp1_gnt_cycle", 64'(gc), 64'(t0 + 1));
        repeat (3) tick();
        chk("tp1_rvalid_cycle", 64'(cpu_rv_cyc), 64'(gc + 2));
        chk("tp1_rdata", 64'(cpu_rdata), 64'h0000_0000_DEAD_BEEF);

        // contested writes: CPU, loader, CPU again
        t0 = cyc;
        fork
            begin
                cpu_op(1'b1, 16'h0004, 32'h11, gc);
                cpu_op(1'b1, 16'h000C, 32'h33, gc2);
            end
            ldr_op(1'b1, 16'h0008, 32'h22, gl);
        join
        chk("tp2_cpu_gnt_cycle", 64'(gc), 64'(t0 + 1));
        chk("tp2_ldr_gnt_cycle", 64'(gl), 64'(t0 + 2));
        chk("tp2_cpu_again_cycle", 64'(gc2), 64'(t0 + 3));
        tick();

        // starvation: CPU reads back-to-back while loader waits
        t0 = cyc;
        fork
            for (int k = 0; k < 12; k++) cpu_op(1'b0, 16'h0040 + 16'(4 * k), 32'h0, gc);
            begin
                ldr_op(1'b1, 16'h0080, 32'h55, gl);
                chk("starve_cnt_after_ldr", 64'(u_a.starve_cnt), 64'd0);
            end
        join
        chk("starve_ldr_gnt_cycle", 64'(gl), 64'(t0 + 25));
        repeat (3) tick();

        // boot_lock: loader only, unlock during last loader RD_WAIT
        boot_lock = 1'b1;
        base = cpu_gnt_seen;
        fork
            cpu_op(1'b0, 16'h0010, 32'h0, gc);
            begin
                ldr_op(1'b0, 16'h0004, 32'h0, gl);
                ldr_op(1'b0, 16'h0008, 32'h0, gl);
                ldr_op(1'b0, 16'h0080, 32'h0, g);
                tick();
                chk("lock_cpu_gnt_count", 64'(cpu_gnt_seen - base), 64'd0);
                boot_lock = 1'b0;
            end
        join
        chk("unlock_cpu_gnt_cycle", 64'(gc), 64'(g + 3));
        repeat (4) tick();
        chk("unlock_ldr_rvalid_cycle", 64'(ldr_rv_cyc), 64'(g + 2));
        chk("lock_ldr_rdata", 64'(ldr_rdata), 64'h55);

        // asynchronous reset during a CPU read's RD_WAIT
        cpu_op(1'b0, 16'h0044, 32'h1234_5678, gc);
        tick();
        prev = cpu_rv_cyc;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cpu_rvalid", 64'(cpu_rvalid), 64'd0);
        chk("arst_cpu_gnt", 64'(cpu_gnt), 64'd0);
        chk("arst_mem_we", 64'(mem_we), 64'd0);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("arst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("arst_ldr_rdata", 64'(ldr_rdata), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("arst_no_rvalid_after", 64'(cpu_rv_cyc), 64'(prev));
        t0 = cyc;
        cpu_op(1'b0, 16'h0010, 32'h0, gc);
        chk("arst_new_gnt_cycle", 64'(gc), 64'(t0 + 1));
        repeat (3) tick();

        // RD_LAT=3 instance: rvalid at T+4, late loader request granted at T+5
        b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = 16'h0010;
        tick();
        chk("b_cpu_gnt", 64'(b_cpu_gnt), 64'd1);
        b_cpu_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("b_cpu_rvalid", 64'(b_cpu_rvalid), 64'(k == 4));
            chk("b_ldr_gnt", 64'(b_ldr_gnt), 64'(k == 5));
            if (k == 4) chk("b_cpu_rdata", 64'(b_cpu_rdata), 64'h0000_0000_DEAD_BEEF);
            if (k == 5) begin
                chk("b_mem_addr", 64'(b_mem_addr), 64'h20);
                chk("b_mem_we", 64'(b_mem_we), 64'd1);
                chk("b_mem_wdata", 64'(b_mem_wdata), 64'h77);
                b_ldr_req = 1'b0;
            end
            if (k == 1) begin
                b_ldr_req = 1'b1; b_ldr_we = 1'b1; b_ldr_addr = 16'h0020; b_ldr_wdata = 32'h77;
            end
        end

        repeat (3) tick();
        chk("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
        chk("ldr_q_drained", 64'(ldr_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data RAM (word-addressed, 32-bit, one write-enable) between two requesters: the CPU MEM stage and the UART program loader.
- Sits between both requesters and the data memory wrapper. It serialises their accesses, times the read return and forwards read data to whichever requester issued the read.
- A boot_lock input gives the loader exclusive access while a program is being loaded.

Parameters:
- ADDR_W, 16, byte address width; memory uses addr[ADDR_W-1:2]
- DATA_W, 32, data width
- RD_LAT, 1, cycles from command issue to valid mem_rdata (>=1)
- STARVE_LIMIT, 8, consecutive CPU wins tolerated while loader waits (>=1)

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- boot_lock  in  1  1 = loader-only mode
- cpu_req  in  1  CPU access request; command held stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  one-cycle pulse: command is on the memory bus this cycle
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata holds the completed read
- cpu_rdata  out  DATA_W  last read data returned to the CPU
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata  same directions and widths as the cpu_* set, for the loader
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM byte address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, all gnt/rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0, both rdata=0, starve counter=0.
  - Any in-flight read is discarded; no rvalid follows.
- FSM states:
  - IDLE.
  - ISSUE: one cycle; mem_* driven from registers; owner's gnt=1; mem_we=1 only for writes.
  - RD_WAIT: RD_LAT cycles.
  - RD_DONE: one cycle; owner rvalid=1.
- Outside ISSUE, mem_we=0; mem_addr and mem_wdata hold their last values.
- Arbitration decision points: IDLE, ISSUE of a write, and RD_DONE.
  - If a winner exists, the next state is ISSUE with that winner's command registered.
  - Otherwise: IDLE from IDLE or from a write ISSUE; IDLE from RD_DONE.
  - From a read ISSUE, the next state is RD_WAIT unconditionally.
- Eligibility:
  - A requester is ineligible in the cycle its own gnt is high. This prevents double-issue of a held command. Consequence: one access per 2 cycles per requester; alternating requesters get one access per cycle.
  - boot_lock=1: only the loader is eligible.
- Priority: CPU wins a contested decision, unless starve_cnt==STARVE_LIMIT, in which case the loader wins.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - +1 on each decision where the CPU wins while ldr_req=1.
  - Cleared when the loader wins, or at any decision with ldr_req=0.
  - Saturates at STARVE_LIMIT.
- Read timing with issue at cycle T:
  - mem_rdata is valid during T+RD_LAT and is captured at the end of that cycle into the owner's rdata.
  - rvalid=1 during T+RD_LAT+1 (the RD_DONE cycle).
  - rdata holds until that owner's next read completes.
  - The non-owner's rdata never changes.
- Write timing: memory updates in the ISSUE cycle; no completion pulse is produced.
- The command owner is latched at issue. A boot_lock change or req deassertion after the grant never redirects or cancels an in-flight read.
- If req drops before gnt, the request is withdrawn and no access occurs.
- Address bits [1:0] are passed through unchanged and are not checked.

Test Plan:
- After reset, CPU read addr 0x0010 with mem_rdata=0xDEADBEEF (RD_LAT=1), req at t0:
  - cpu_gnt at t1, mem_addr=0x0010, mem_we=0.
  - cpu_rvalid at t3, cpu_rdata=0xDEADBEEF.
- Both request writes at t0 (CPU 0x0004/0x11, loader 0x0008/0x22):
  - t1: CPU granted, mem_we=1, mem_addr=0x0004.
  - t2: loader granted, mem_addr=0x0008, mem_wdata=0x22.
  - t3: CPU granted again if still requesting.
- Starvation: CPU issues writes continuously while the loader holds ldr_req, STARVE_LIMIT=8:
  - The loader is granted no later than the 9th decision.
  - The counter then reads 0.
- boot_lock=1 with both requesting reads:
  - Only ldr_gnt pulses; cpu_gnt stays 0 indefinitely.
  - Deasserting boot_lock while a loader read is in RD_WAIT: ldr_rvalid still fires and cpu_rdata is unchanged.
- rst_n pulsed low during RD_WAIT of a CPU read:
  - All outputs are 0 immediately (asynchronous).
  - No cpu_rvalid appears after rst_n rises.
  - A new CPU request is granted 1 cycle after it is sampled.
- RD_LAT=3: read issued at T:
  - rvalid at T+4.
  - A loader request raised at T+1 is granted at T+5, not earlier.
